// File: rtl/execute_wb_arb.sv
// rtl/execute_wb_arb.sv - per-channel result FIFOs arbitrated onto one writeback port
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   flush              discards every buffered result, drops this cycle's inputs
//   fu_valid/fu_ready  per-channel result handshake (NUM_FU bits)
//   fu_rd, fu_data     per-channel destination register (5b) and result (DATA_W), packed
//   wb_valid/wb_ready  writeback handshake
//   wb_rd, wb_data     head of the granted FIFO
//   wb_fu_id           index of the granted channel
//   fu_count           per-channel occupancy, packed (CW bits each)
module execute_wb_arb #(
    parameter int NUM_FU   = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int ARB_MODE = 0,
    localparam int IDW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*5-1:0]      fu_rd,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [4:0]               wb_rd,
    output logic [DATA_W-1:0]        wb_data,
    output logic [IDW-1:0]           wb_fu_id,
    output logic [NUM_FU*CW-1:0]     fu_count
);

    logic [4:0]        rd_mem_q   [NUM_FU][DEPTH];
    logic [DATA_W-1:0] data_mem_q [NUM_FU][DEPTH];
    logic [PW-1:0]     wptr_q [NUM_FU], wptr_d [NUM_FU];
    logic [PW-1:0]     rptr_q [NUM_FU], rptr_d [NUM_FU];
    logic [CW-1:0]     cnt_q  [NUM_FU], cnt_d  [NUM_FU];
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [IDW-1:0]    lock_id_q, lock_id_d;

    logic [NUM_FU-1:0] req, push, pop;
    logic [IDW-1:0]    grant;
    logic              found;
    logic              wb_fire;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req[i]      = (cnt_q[i] != '0);
            fu_ready[i] = (cnt_q[i] != CW'(DEPTH)) && !flush;
            // rd==0 results are handshaken but never stored
            push[i]     = fu_valid[i] && fu_ready[i] && (fu_rd[i*5 +: 5] != 5'd0);
            fu_count[i*CW +: CW] = cnt_q[i];
        end
    end

    assign wb_valid = (|req) && !flush;
    assign wb_fire  = wb_valid && wb_ready;

    // Once a grant has been presented and stalled, it is held in lock_id_q so a
    // newly arriving requester cannot steal the port mid-stall.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!found && req[i]) begin
                    grant = IDW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (!found && req[(int'(rr_ptr_q) + k) % NUM_FU]) begin
                    grant = IDW'((int'(rr_ptr_q) + k) % NUM_FU);
                    found = 1'b1;
                end
            end
        end
    end

    assign wb_fu_id = grant;
    assign wb_rd    = rd_mem_q[grant][rptr_q[grant]];
    assign wb_data  = data_mem_q[grant][rptr_q[grant]];

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = wb_fire && (grant == IDW'(i));
            if (flush) begin
                cnt_d[i]  = '0;
                wptr_d[i] = '0;
                rptr_d[i] = '0;
            end else begin
                cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                wptr_d[i] = wptr_q[i] + PW'(push[i]);
                rptr_d[i] = rptr_q[i] + PW'(pop[i]);
            end
        end
        rr_ptr_d  = rr_ptr_q;
        if (wb_fire)
            rr_ptr_d = (grant == IDW'(NUM_FU - 1)) ? '0 : grant + IDW'(1);
        lock_d    = wb_valid && !wb_ready;
        lock_id_d = grant;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (!RST && push[i]) begin
                rd_mem_q[i][wptr_q[i]]   <= fu_rd[i*5 +: 5];
                data_mem_q[i][wptr_q[i]] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_execute_wb_arb.sv
// tb/tb_execute_wb_arb.sv - directed bench for execute_wb_arb (round-robin and fixed-priority instances)
module tb_execute_wb_arb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [19:0] fu_rd;
    logic [127:0] fu_data;
    logic        wb_ready;

    logic [3:0]  fu_ready, fu_ready_fp;
    logic        wb_valid, wb_valid_fp;
    logic [4:0]  wb_rd, wb_rd_fp;
    logic [31:0] wb_data, wb_data_fp;
    logic [1:0]  wb_fu_id, wb_fu_id_fp;
    logic [7:0]  fu_count, fu_count_fp;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    execute_wb_arb #(.NUM_FU(4), .DATA_W(32), .DEPTH(2), .ARB_MODE(0)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_data(fu_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_fu_id(wb_fu_id), .fu_count(fu_count)
    );

    execute_wb_arb #(.NUM_FU(4), .DATA_W(32), .DEPTH(2), .ARB_MODE(1)) dut_fp (
        .CLK(CLK), .RST(RST), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready_fp), .fu_rd(fu_rd), .fu_data(fu_data),
        .wb_valid(wb_valid_fp), .wb_ready(wb_ready), .wb_rd(wb_rd_fp), .wb_data(wb_data_fp),
        .wb_fu_id(wb_fu_id_fp), .fu_count(fu_count_fp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; flush = 1'b0; fu_valid = '0; fu_rd = '0; fu_data = '0; wb_ready = 1'b0;
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fu_count", fu_count, 0);
        chk("rst_fu_ready", fu_ready, 4'hf);
        chk("rst_fp_wb_valid", wb_valid_fp, 0);

        // single path
        fu_valid = 4'b0001; fu_rd[4:0] = 5'd5; fu_data[31:0] = 32'hDEADBEEF; wb_ready = 1'b1;
        tick();
        fu_valid = '0;
        #1;
        chk("single_valid", wb_valid, 1);
        chk("single_rd", wb_rd, 5);
        chk("single_data", wb_data, 32'hDEADBEEF);
        chk("single_id", wb_fu_id, 0);
        tick();
        chk("single_empty", wb_valid, 0);

        // fairness / fixed priority: reset so rr_ptr starts at 0
        RST = 1'b1; tick(); RST = 1'b0;
        wb_ready = 1'b0;
        fu_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            fu_rd[c*5 +: 5] = 5'(c + 1);
            fu_data[c*32 +: 32] = 32'(c * 16);
        end
        tick();
        for (int c = 0; c < 4; c++) fu_data[c*32 +: 32] = 32'(c * 16 + 1);
        tick();
        fu_valid = '0;
        #1;
        chk("load_count", fu_count, 8'hAA);
        chk("load_ready", fu_ready, 4'h0);
        wb_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_valid%0d", k), wb_valid, 1);
            chk($sformatf("rr_id%0d", k), wb_fu_id, k % 4);
            chk($sformatf("rr_data%0d", k), wb_data, (k % 4) * 16 + k / 4);
            chk($sformatf("fp_id%0d", k), wb_fu_id_fp, k / 2);
            chk($sformatf("fp_data%0d", k), wb_data_fp, (k / 2) * 16 + k % 2);
            tick();
        end
        chk("rr_drained", wb_valid, 0);
        chk("fp_drained", wb_valid_fp, 0);

        // backpressure and full on channel 2
        wb_ready = 1'b0;
        fu_valid = 4'b0100; fu_rd[14:10] = 5'd7; fu_data[95:64] = 32'hA1;
        #1;
        chk("bp_ready0", fu_ready, 4'hf);
        tick();
        fu_data[95:64] = 32'hA2;
        #1;
        chk("bp_count1", fu_count, 8'h10);
        tick();
        fu_data[95:64] = 32'hA3;
        fu_valid = 4'b0101; fu_rd[4:0] = 5'd9; fu_data[31:0] = 32'h55;
        #1;
        chk("bp_full_ready", fu_ready, 4'b1011);
        chk("bp_count2", fu_count, 8'h20);
        chk("bp_rd", wb_rd, 7);
        chk("bp_data", wb_data, 32'hA1);
        tick();
        fu_valid = '0;
        #1;
        chk("bp_count_after", fu_count, 8'h21);
        chk("bp_hold_id", wb_fu_id, 2);
        chk("bp_hold_id_fp", wb_fu_id_fp, 2);
        chk("bp_hold_data", wb_data, 32'hA1);

        // flush with 5 entries buffered
        fu_valid = 4'b0010; fu_rd[9:5] = 5'd3; fu_data[63:32] = 32'h77;
        tick(); tick();
        fu_valid = '0;
        #1;
        chk("pre_flush_count", fu_count, 8'h29);
        flush = 1'b1; fu_valid = 4'b1000; fu_rd[19:15] = 5'd3;
        #1;
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_ready", fu_ready, 4'h0);
        tick();
        flush = 1'b0; fu_valid = '0;
        #1;
        chk("post_flush_valid", wb_valid, 0);
        chk("post_flush_count", fu_count, 0);
        chk("post_flush_ready", fu_ready, 4'hf);

        // rd=0 drop
        fu_valid = 4'b0010; fu_rd[9:5] = 5'd0;
        #1;
        chk("rd0_ready", fu_ready, 4'hf);
        tick();
        fu_valid = '0;
        #1;
        chk("rd0_count", fu_count, 0);
        chk("rd0_no_wb", wb_valid, 0);

        // bring rr_ptr to 2 via a writeback from channel 1
        wb_ready = 1'b1; fu_valid = 4'b0010; fu_rd[9:5] = 5'd4;
        tick();
        fu_valid = '0;
        #1;
        chk("ch1_valid", wb_valid, 1);
        chk("ch1_id", wb_fu_id, 1);
        tick();
        chk("rr_ptr2", dut.rr_ptr_q, 2);

        // stall with channels 0 and 3 pending, then reset mid-stall
        wb_ready = 1'b0; fu_valid = 4'b1001; fu_rd[4:0] = 5'd6; fu_rd[19:15] = 5'd8;
        tick();
        fu_valid = '0;
        #1;
        chk("stall_rr_id", wb_fu_id, 3);
        chk("stall_fp_id", wb_fu_id_fp, 0);
        tick();
        RST = 1'b1; fu_valid = 4'b1111; fu_rd = {5'd1, 5'd2, 5'd3, 5'd4}; wb_ready = 1'b1;
        tick();
        RST = 1'b0; fu_valid = '0; wb_ready = 1'b0;
        #1;
        chk("rst_rr_ptr", dut.rr_ptr_q, 0);
        chk("rst2_wb_valid", wb_valid, 0);
        chk("rst2_count", fu_count, 0);
        chk("rst2_ready", fu_ready, 4'hf);
        chk("rst2_fp_count", fu_count_fp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
